param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/counter_pkg.sv | 17 +
 rtl/udc_next_step.sv | 95 +++++++++
 rtl/param_updown_counter.sv | 70 +++++++
 tb/tb_param_updown_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the parameterised up/down/bounce counter.
// Holds the mode enum and the bounce-phase enum.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        UP_PH   = 1'b0,
        DOWN_PH = 1'b1
    } phase_e;

endpackage

// File: rtl/udc_next_step.sv
// Combinational next-step logic for param_updown_counter.
// Ports: count/mode/phase in; count_nxt, phase_nxt, evt out.
// With COUNTER_LOAD_EN: load_val in, load_clamp out (clamped to MODULUS-1).
module udc_next_step
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic [1:0]       mode,
    input  logic             phase,
`ifdef COUNTER_LOAD_EN
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] load_clamp,
`endif
    output logic [WIDTH-1:0] count_nxt,
    output logic             phase_nxt,
    output logic             evt
);

    // One extra bit so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] c;
    logic [WIDTH:0] nxt;
    logic           at_max;
    logic           at_min;
    phase_e         cur_ph;
    phase_e         eff_ph;
    phase_e         ph;

    assign c      = {1'b0, count};
    assign at_max = (c == MAXV);
    assign at_min = (c == '0);
    assign cur_ph = phase_e'(phase);

`ifdef COUNTER_LOAD_EN
    assign load_clamp = ({1'b0, load_val} >= MAXV + 1'b1)
                      ? MAXV[WIDTH-1:0] : load_val;
`endif

    always_comb begin
        nxt    = c;
        ph     = cur_ph;
        evt    = 1'b0;
        eff_ph = cur_ph;
        unique case (mode_e'(mode))
            MODE_UP: begin
                ph = UP_PH;
                if (at_max) begin
                    evt = 1'b1;
                    nxt = (SATURATE != 0) ? MAXV : '0;
                end else begin
                    nxt = c + 1'b1;
                end
            end
            MODE_DOWN: begin
                ph = DOWN_PH;
                if (at_min) begin
                    evt = 1'b1;
                    nxt = (SATURATE != 0) ? '0 : MAXV;
                end else begin
                    nxt = c - 1'b1;
                end
            end
            MODE_BOUNCE: begin
                // Endpoints force the direction; otherwise keep the phase,
                // which mirrors dir, so entry from up/down inherits dir.
                if (at_max)
                    eff_ph = DOWN_PH;
                else if (at_min)
                    eff_ph = UP_PH;
                nxt = (eff_ph == UP_PH) ? c + 1'b1 : c - 1'b1;
                // Phase flips on reaching an endpoint.
                if (nxt == MAXV)
                    ph = DOWN_PH;
                else if (nxt == '0)
                    ph = UP_PH;
                else
                    ph = eff_ph;
                // A turnaround is any change of direction.
                evt = (ph != cur_ph);
            end
            MODE_HOLD: begin
                nxt = c;
            end
        endcase
    end

    assign count_nxt = nxt[WIDTH-1:0];
    assign phase_nxt = ph;

endmodule

// File: rtl/param_updown_counter.sv
// Up/down/bounce counter with wrap or saturate, registered count/dir/tc.
// Ports: clk, reset (sync, active-low), en, mode, count, dir, tc;
// load/load_val exist only when COUNTER_LOAD_EN is defined.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    phase_e           phase;
    logic [WIDTH-1:0] count_nxt;
    logic             phase_nxt;
    logic             evt;
`ifdef COUNTER_LOAD_EN
    logic [WIDTH-1:0] load_clamp;
`endif

    udc_next_step #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_step (
        .count      (count),
        .mode       (mode),
        .phase      (phase),
`ifdef COUNTER_LOAD_EN
        .load_val   (load_val),
        .load_clamp (load_clamp),
`endif
        .count_nxt  (count_nxt),
        .phase_nxt  (phase_nxt),
        .evt        (evt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            dir   <= 1'b1;
            tc    <= 1'b0;
            phase <= UP_PH;
`ifdef COUNTER_LOAD_EN
        end else if (load) begin
            count <= load_clamp;
            tc    <= 1'b0;
`endif
        end else if (en) begin
            count <= count_nxt;
            phase <= phase_e'(phase_nxt);
            dir   <= (phase_e'(phase_nxt) == UP_PH);
            tc    <= evt;
        end else begin
            tc    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: wrap (M=10), saturate (M=10) and full-range (M=16)
// instances driven from one linear stimulus sequence.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_w, en_s, en_f;
    logic [1:0] mode;
`ifdef COUNTER_LOAD_EN
    logic       load;
    logic [3:0] load_val;
`endif
    logic [3:0] w_cnt, s_cnt, f_cnt;
    logic       w_dir, s_dir, f_dir;
    logic       w_tc, s_tc, f_tc;

    int checks   = 0;
    int failures = 0;

    // Bounce from 0 for 20 steps: count, dir and tc after each step.
    int bc[20] = '{1,2,3,4,5,6,7,8,9,8,7,6,5,4,3,2,1,0,1,2};
    int bd[20] = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,1,1,1};
    int bt[20] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,1,0,0};

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_w (
        .clk(clk), .reset(reset), .en(en_w), .mode(mode),
`ifdef COUNTER_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count(w_cnt), .dir(w_dir), .tc(w_tc)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s (
        .clk(clk), .reset(reset), .en(en_s), .mode(mode),
`ifdef COUNTER_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count(s_cnt), .dir(s_dir), .tc(s_tc)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_f (
        .clk(clk), .reset(reset), .en(en_f), .mode(mode),
`ifdef COUNTER_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count(f_cnt), .dir(f_dir), .tc(f_tc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        en_w  = 1'b1;
        en_s  = 1'b1;
        en_f  = 1'b1;
        mode  = 2'b00;
`ifdef COUNTER_LOAD_EN
        load     = 1'b0;
        load_val = 4'd0;
`endif
        // Reset wins over en.
        step();
        chk("rst_cnt_w", int'(w_cnt), 0);
        chk("rst_dir_w", int'(w_dir), 1);
        chk("rst_tc_w",  int'(w_tc),  0);
        chk("rst_cnt_s", int'(s_cnt), 0);
        chk("rst_cnt_f", int'(f_cnt), 0);

        // Up, wrap at 9.
        reset = 1'b1;
        en_s  = 1'b0;
        en_f  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("up_cnt", int'(w_cnt), (i + 1) % 10);
            chk("up_tc",  int'(w_tc),  (i == 9) ? 1 : 0);
            chk("up_dir", int'(w_dir), 1);
        end

        // en low and hold mode.
        en_w = 1'b0;
        step();
        chk("en0_cnt", int'(w_cnt), 2);
        chk("en0_tc",  int'(w_tc),  0);
        en_w = 1'b1;
        mode = 2'b11;
        step();
        chk("hold_cnt", int'(w_cnt), 2);
        chk("hold_tc",  int'(w_tc),  0);

        // Down, then bounce entered at 0 with dir=0.
        mode = 2'b01;
        step();
        chk("dn1_cnt", int'(w_cnt), 1);
        chk("dn1_dir", int'(w_dir), 0);
        step();
        chk("dn0_cnt", int'(w_cnt), 0);
        chk("dn0_tc",  int'(w_tc),  0);
        mode = 2'b10;
        step();
        chk("ent_cnt", int'(w_cnt), 1);
        chk("ent_dir", int'(w_dir), 1);
        chk("ent_tc",  int'(w_tc),  1);
        step();
        chk("ent2_cnt", int'(w_cnt), 2);
        chk("ent2_tc",  int'(w_tc),  0);
        mode = 2'b01;
        step();
        chk("sw_cnt", int'(w_cnt), 1);
        chk("sw_dir", int'(w_dir), 0);
        step();
        step();
        chk("dnw_cnt", int'(w_cnt), 9);
        chk("dnw_tc",  int'(w_tc),  1);
        mode = 2'b00;
        step();
        chk("upw_cnt", int'(w_cnt), 0);
        chk("upw_tc",  int'(w_tc),  1);
        chk("upw_dir", int'(w_dir), 1);

        // Bounce from reset, then reset while descending at 6.
        reset = 1'b0;
        step();
        chk("rst2_cnt", int'(w_cnt), 0);
        reset = 1'b1;
        mode  = 2'b10;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("bpre_cnt", int'(w_cnt), bc[i]);
            chk("bpre_tc",  int'(w_tc),  bt[i]);
        end
        chk("bpre_dir", int'(w_dir), 0);
        reset = 1'b0;
        step();
        chk("rstm_cnt", int'(w_cnt), 0);
        chk("rstm_dir", int'(w_dir), 1);
        chk("rstm_tc",  int'(w_tc),  0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bnc_cnt", int'(w_cnt), bc[i]);
            chk("bnc_dir", int'(w_dir), bd[i]);
            chk("bnc_tc",  int'(w_tc),  bt[i]);
        end

        // Saturating instance: down from 2 clamps at 0.
        reset = 1'b0;
        en_w  = 1'b0;
        step();
        reset = 1'b1;
        en_s  = 1'b1;
        mode  = 2'b00;
        step();
        step();
        chk("sat_pre", int'(s_cnt), 2);
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sat_cnt", int'(s_cnt), (i == 0) ? 1 : 0);
            chk("sat_tc",  int'(s_tc),  (i >= 2) ? 1 : 0);
        end
        chk("sat_dir", int'(s_dir), 0);

        // Full-range instance: 15 wraps to 0.
        en_s = 1'b0;
        en_f = 1'b1;
        mode = 2'b00;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("full_cnt", int'(f_cnt), i + 1);
        end
        chk("full_tc0", int'(f_tc), 0);
        step();
        chk("full_wrap", int'(f_cnt), 0);
        chk("full_tc",   int'(f_tc),  1);
        en_f = 1'b0;

`ifdef COUNTER_LOAD_EN
        // Load clamps and beats en; dir untouched.
        en_w     = 1'b1;
        load     = 1'b1;
        load_val = 4'd13;
        step();
        chk("ld_cnt", int'(w_cnt), 9);
        chk("ld_tc",  int'(w_tc),  0);
        chk("ld_dir", int'(w_dir), 1);
        load = 1'b0;
        step();
        chk("ld_up_cnt", int'(w_cnt), 0);
        chk("ld_up_tc",  int'(w_tc),  1);
        load     = 1'b1;
        load_val = 4'd5;
        step();
        chk("ld5_cnt", int'(w_cnt), 5);
        load = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
